// File: rtl/qkv_stream_scheduler.sv
// qkv_stream_scheduler: streams Q, K, V rows of one attention tile from SRAMs and detects tile completion from retired scores

// One stream: read issue/address generation, 1-bit pending flag and a 2-entry output FIFO
module qkv_stream_lane #(
    parameter int DW    = 16,
    parameter int TOTAL = 1,
    parameter int WRAP  = 1,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic          vld_o,
    input  logic          rdy_i,
    output logic [DW-1:0] data_o,
    output logic          all_issued_o,
    output logic          idle_o
);
    localparam int CW = $clog2(TOTAL + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    occ_q, occ_d;
    logic          pend_q, head_q, pop, issue;
    logic [DW-1:0] mem_q [2];

    // Issue only while the FIFO plus the in-flight read leave room after this cycle's pop
    always_comb begin
        pop    = (occ_q != 2'd0) && rdy_i;
        issue  = en_i && (cnt_q < CW'(TOTAL)) && ((3'(occ_q) + 3'(pend_q)) < (3'd2 + 3'(pop)));
        occ_d  = occ_q + 2'(pend_q) - 2'(pop);
        cnt_d  = clr_i ? '0 : cnt_q + CW'(issue);
        addr_d = clr_i ? '0 : !issue ? addr_q : (addr_q == AW'(WRAP - 1)) ? '0 : addr_q + AW'(1);
    end

    // Counters, occupancy and the pending flag; the returning word is pushed one cycle after rd_en
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            occ_q  <= '0;
            pend_q <= 1'b0;
            head_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            occ_q  <= occ_d;
            pend_q <= issue;
            head_q <= head_q ^ pop;
        end
    end

    // FIFO storage: the tail slot is head + occupancy modulo 2
    always_ff @(posedge clk) begin
        if (pend_q) mem_q[head_q ^ occ_q[0]] <= rd_data_i;
    end

    assign rd_en_o      = issue;
    assign rd_addr_o    = addr_q;
    assign vld_o        = occ_q != 2'd0;
    assign data_o       = mem_q[head_q];
    assign all_issued_o = cnt_q == CW'(TOTAL);
    assign idle_o       = (occ_q == 2'd0) && !pend_q;

    a_hold:  assert property (@(posedge clk) disable iff (rst) vld_o && !rdy_i |=> vld_o && $stable(data_o));
    a_room:  assert property (@(posedge clk) disable iff (rst) (3'(occ_q) + 3'(pend_q)) <= 3'd2);
    a_range: assert property (@(posedge clk) disable iff (rst) rd_en_o |-> 32'(rd_addr_o) < WRAP);
endmodule

module qkv_stream_scheduler #(
    parameter int SEQ_LEN = 4,
    parameter int NUM_Q   = 2,
    parameter int DW      = 16,
    parameter int Q_AW    = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    parameter int KV_AW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             q_rd_en,
    output logic [Q_AW-1:0]  q_rd_addr,
    input  logic [DW-1:0]    q_rd_data,
    output logic             k_rd_en,
    output logic [KV_AW-1:0] k_rd_addr,
    input  logic [DW-1:0]    k_rd_data,
    output logic             v_rd_en,
    output logic [KV_AW-1:0] v_rd_addr,
    input  logic [DW-1:0]    v_rd_data,
    output logic             q_vld_out,
    input  logic             q_rdy_in,
    output logic [DW-1:0]    q_out,
    output logic             k_vld_out,
    input  logic             k_rdy_in,
    output logic [DW-1:0]    k_out,
    output logic             v_vld_out,
    input  logic             v_rdy_in,
    output logic [DW-1:0]    v_out,
    input  logic             score_fire
);
    localparam int TOT = NUM_Q * SEQ_LEN;
    localparam int SW  = $clog2(TOT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] score_cnt_q, score_cnt_d;
    logic          run, clr, q_all, k_all, v_all, q_idle, k_idle, v_idle;

    assign run  = state_q == RUN;
    assign clr  = state_q == IDLE;
    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = state_q == DONE;

    qkv_stream_lane #(.DW(DW), .TOTAL(NUM_Q), .WRAP(NUM_Q), .AW(Q_AW)) u_q (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(run),
        .rd_en_o(q_rd_en), .rd_addr_o(q_rd_addr), .rd_data_i(q_rd_data),
        .vld_o(q_vld_out), .rdy_i(q_rdy_in), .data_o(q_out),
        .all_issued_o(q_all), .idle_o(q_idle)
    );

    qkv_stream_lane #(.DW(DW), .TOTAL(TOT), .WRAP(SEQ_LEN), .AW(KV_AW)) u_k (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(run),
        .rd_en_o(k_rd_en), .rd_addr_o(k_rd_addr), .rd_data_i(k_rd_data),
        .vld_o(k_vld_out), .rdy_i(k_rdy_in), .data_o(k_out),
        .all_issued_o(k_all), .idle_o(k_idle)
    );

    qkv_stream_lane #(.DW(DW), .TOTAL(TOT), .WRAP(SEQ_LEN), .AW(KV_AW)) u_v (
        .clk(clk), .rst(rst), .clr_i(clr), .en_i(run),
        .rd_en_o(v_rd_en), .rd_addr_o(v_rd_addr), .rd_data_i(v_rd_data),
        .vld_o(v_vld_out), .rdy_i(v_rdy_in), .data_o(v_out),
        .all_issued_o(v_all), .idle_o(v_idle)
    );

    // Tile sequencing and saturating count of retired scores (cleared while idle)
    always_comb begin
        state_d     = state_q;
        score_cnt_d = clr ? '0 : (busy && score_fire && (score_cnt_q < SW'(TOT))) ? score_cnt_q + SW'(1) : score_cnt_q;
        unique case (state_q)
            IDLE:  state_d = start ? RUN : IDLE;
            RUN:   state_d = (q_all && k_all && v_all) ? DRAIN : RUN;
            DRAIN: state_d = (q_idle && k_idle && v_idle && (score_cnt_q == SW'(TOT))) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
        endcase
    end

    // State and score counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            score_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            score_cnt_q <= score_cnt_d;
        end
    end
endmodule

// File: tb/tb_qkv_stream_scheduler.sv
// tb_qkv_stream_scheduler: randomized scoreboard bench for the Q/K/V tile scheduler
module tb_qkv_stream_scheduler;
    localparam int SL = 4, NQ = 2, DW = 16;

    logic clk = 0, rst = 1, start = 0;
    logic busy, done, q_rd_en, k_rd_en, v_rd_en, q_vld, k_vld, v_vld;
    logic q_rdy = 0, k_rdy = 0, v_rdy = 0, score_fire = 0;
    logic [0:0] q_rd_addr;
    logic [1:0] k_rd_addr, v_rd_addr;
    logic [DW-1:0] q_rd_data, k_rd_data, v_rd_data, q_out, k_out, v_out;

    logic s_start = 0, s_busy, s_done, s_q_rd_en, s_k_rd_en, s_v_rd_en, s_q_vld, s_k_vld, s_v_vld;
    logic [0:0] s_q_rd_addr, s_k_rd_addr, s_v_rd_addr;
    logic [DW-1:0] s_q_out, s_k_out, s_v_out;

    always #5 clk = ~clk;

    qkv_stream_scheduler #(.SEQ_LEN(SL), .NUM_Q(NQ), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .k_rd_en(k_rd_en), .k_rd_addr(k_rd_addr), .k_rd_data(k_rd_data),
        .v_rd_en(v_rd_en), .v_rd_addr(v_rd_addr), .v_rd_data(v_rd_data),
        .q_vld_out(q_vld), .q_rdy_in(q_rdy), .q_out(q_out),
        .k_vld_out(k_vld), .k_rdy_in(k_rdy), .k_out(k_out),
        .v_vld_out(v_vld), .v_rdy_in(v_rdy), .v_out(v_out),
        .score_fire(score_fire)
    );

    qkv_stream_scheduler #(.SEQ_LEN(1), .NUM_Q(1), .DW(DW)) sdut (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .q_rd_en(s_q_rd_en), .q_rd_addr(s_q_rd_addr), .q_rd_data(16'h0011),
        .k_rd_en(s_k_rd_en), .k_rd_addr(s_k_rd_addr), .k_rd_data(16'h0022),
        .v_rd_en(s_v_rd_en), .v_rd_addr(s_v_rd_addr), .v_rd_data(16'h0033),
        .q_vld_out(s_q_vld), .q_rdy_in(1'b1), .q_out(s_q_out),
        .k_vld_out(s_k_vld), .k_rdy_in(1'b1), .k_out(s_k_out),
        .v_vld_out(s_v_vld), .v_rdy_in(1'b1), .v_out(s_v_out),
        .score_fire(s_k_vld)
    );

    logic [DW-1:0] qmem [NQ];
    logic [DW-1:0] kmem [SL];
    logic [DW-1:0] vmem [SL];

    // SRAM models: data returns exactly one cycle after the read strobe
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= qmem[q_rd_addr];
        if (k_rd_en) k_rd_data <= kmem[k_rd_addr];
        if (v_rd_en) v_rd_data <= vmem[v_rd_addr];
    end

    int checks = 0, failures = 0;
    int qpop, kpop, vpop, kiss, done_cnt, fires, fire_limit = 1000;
    bit rnd = 0, hold_q = 0, hold_k = 0;
    int unsigned cyc = 0;
    int unsigned fire_q[$];
    logic [DW-1:0] exp_q[$], exp_k[$], exp_v[$];
    int exp_qa[$], exp_ka[$], exp_va[$];
    logic pk_v = 0, pk_r = 0, pq_v = 0, pq_r = 0;
    logic [DW-1:0] pk_d, pq_d;

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endfunction

    // Consumer ready and score generation: each K acceptance retires a score three cycles later
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        q_rdy = !hold_q && (!rnd || $urandom_range(3, 0) != 0);
        k_rdy = !hold_k && (!rnd || $urandom_range(3, 0) != 0);
        v_rdy = !rnd || $urandom_range(3, 0) != 0;
        score_fire = !rst && fire_q.size() > 0 && fire_q[0] <= cyc && fires < fire_limit;
        if (score_fire) begin
            void'(fire_q.pop_front());
            fires++;
        end
    end

    // Monitor: compares addresses and accepted words against the expected queues
    always @(negedge clk) begin
        if (rst) begin
            pk_v = 0;
            pq_v = 0;
        end else begin
            if (q_rd_en) begin
                if (exp_qa.size() == 0) chk("q_addr_extra", 1, 0); else chk("q_addr", 32'(q_rd_addr), exp_qa.pop_front());
            end
            if (k_rd_en) begin
                kiss++;
                if (exp_ka.size() == 0) chk("k_addr_extra", 1, 0); else chk("k_addr", 32'(k_rd_addr), exp_ka.pop_front());
            end
            if (v_rd_en) begin
                if (exp_va.size() == 0) chk("v_addr_extra", 1, 0); else chk("v_addr", 32'(v_rd_addr), exp_va.pop_front());
            end
            if (q_vld && q_rdy) begin
                qpop++;
                if (exp_q.size() == 0) chk("q_extra", 1, 0); else chk("q_data", 32'(q_out), 32'(exp_q.pop_front()));
            end
            if (k_vld && k_rdy) begin
                kpop++;
                fire_q.push_back(cyc + 3);
                if (exp_k.size() == 0) chk("k_extra", 1, 0); else chk("k_data", 32'(k_out), 32'(exp_k.pop_front()));
            end
            if (v_vld && v_rdy) begin
                vpop++;
                if (exp_v.size() == 0) chk("v_extra", 1, 0); else chk("v_data", 32'(v_out), 32'(exp_v.pop_front()));
            end
            if (pk_v && !pk_r) begin
                chk("k_hold_vld", 32'(k_vld), 1);
                chk("k_hold_data", 32'(k_out), 32'(pk_d));
            end
            if (pq_v && !pq_r) begin
                chk("q_hold_vld", 32'(q_vld), 1);
                chk("q_hold_data", 32'(q_out), 32'(pq_d));
            end
            chk("k_outstanding_le2", 32'(kiss - kpop <= 2), 1);
            if (done) done_cnt++;
            pk_v = k_vld; pk_r = k_rdy; pk_d = k_out;
            pq_v = q_vld; pq_r = q_rdy; pq_d = q_out;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(string n);
        chk({n, "_busy"}, 32'(busy), 0);
        chk({n, "_done"}, 32'(done), 0);
        chk({n, "_rd_en"}, 32'({q_rd_en, k_rd_en, v_rd_en}), 0);
        chk({n, "_vld"}, 32'({q_vld, k_vld, v_vld}), 0);
    endtask

    task automatic flush();
        exp_q.delete(); exp_k.delete(); exp_v.delete();
        exp_qa.delete(); exp_ka.delete(); exp_va.delete();
        fire_q.delete();
        qpop = 0; kpop = 0; vpop = 0; kiss = 0; done_cnt = 0; fires = 0;
    endtask

    // Modes: 0 all ready + start pulses, 1 random ready + K stall, 2 Q backpressure, 3 score short, 4 reset abort
    task automatic run_tile(int mode);
        int n, t, k0;
        @(posedge clk);
        #3;
        flush();
        for (int i = 0; i < NQ; i++) begin
            qmem[i] = DW'($urandom);
            exp_q.push_back(qmem[i]);
            exp_qa.push_back(i);
        end
        for (int j = 0; j < SL; j++) begin
            kmem[j] = DW'($urandom);
            vmem[j] = DW'($urandom);
        end
        for (int r = 0; r < NQ; r++)
            for (int j = 0; j < SL; j++) begin
                exp_k.push_back(kmem[j]); exp_ka.push_back(j);
                exp_v.push_back(vmem[j]); exp_va.push_back(j);
            end
        rnd = mode == 1;
        hold_q = 0;
        hold_k = 0;
        fire_limit = mode == 3 ? 7 : 1000;
        start = 1;
        sync();
        start = 0;
        chk("lat_busy", 32'(busy), 1);
        chk("lat_rd_en", 32'({q_rd_en, k_rd_en, v_rd_en}), 32'h7);
        sync();
        chk("lat_vld_early", 32'({q_vld, k_vld, v_vld}), 0);
        sync();
        chk("lat_vld", 32'({q_vld, k_vld, v_vld}), 32'h7);
        if (mode == 0) begin
            sync();
            start = 1;
            sync();
            start = 0;
        end
        if (mode == 1) begin
            n = 0;
            for (t = 0; t < 200 && n < 2; t++) begin
                @(negedge clk);
                if (k_vld && k_rdy) n++;
            end
            hold_k = 1;
            repeat (10) @(negedge clk);
            chk("k_stall_outstanding", 32'(kiss - kpop), 2);
            chk("k_stall_vld", 32'(k_vld), 1);
            hold_k = 0;
        end
        if (mode == 2) begin
            for (t = 0; t < 50; t++) begin
                @(negedge clk);
                if (q_vld && q_rdy) break;
            end
            hold_q = 1;
            k0 = kpop;
            repeat (12) @(negedge clk);
            chk("q_prefetch_vld", 32'(q_vld), 1);
            chk("q_prefetch_data", 32'(q_out), 32'(qmem[1]));
            chk("kv_flow_during_q_stall", 32'(kpop > k0), 1);
            hold_q = 0;
        end
        if (mode == 3) begin
            for (t = 0; t < 300 && !(kpop == NQ * SL && vpop == NQ * SL && qpop == NQ); t++) @(negedge clk);
            repeat (10) @(negedge clk);
            chk("short_busy", 32'(busy), 1);
            chk("short_done", 32'(done), 0);
            chk("short_done_cnt", 32'(done_cnt), 0);
            fire_limit = 8;
            sync();
            chk("last_fire_done0", 32'(done), 0);
            sync();
            chk("last_fire_done1", 32'(done), 0);
            sync();
            chk("last_fire_done2", 32'(done), 1);
            sync();
            chk("done_one_cycle", 32'(done), 0);
        end
        if (mode == 4) begin
            repeat (3) sync();
            rst = 1;
            sync();
            chk_all_zero("abort");
            flush();
            rst = 0;
            sync();
            chk("abort_idle", 32'(busy), 0);
            return;
        end
        if (mode != 3) begin
            for (t = 0; t < 400; t++) begin
                @(negedge clk);
                if (done) break;
            end
            if (t == 400) chk("done_timeout", 1, 0);
            if (mode == 0) begin
                start = 1;
                sync();
                start = 0;
                chk("start_in_done_busy", 32'(busy), 0);
                sync();
                chk("start_in_done_idle", 32'({busy, q_rd_en}), 0);
            end
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("q_count", 32'(qpop), NQ);
        chk("k_count", 32'(kpop), NQ * SL);
        chk("v_count", 32'(vpop), NQ * SL);
        chk("leftover", 32'(exp_q.size() + exp_k.size() + exp_v.size() + exp_ka.size()), 0);
    endtask

    initial begin
        int sq, sk, sv, sd;
        start = 1;
        repeat (2) sync();
        chk_all_zero("reset");
        rst = 0;
        start = 0;
        sync();
        chk("start_with_rst_ignored", 32'(busy), 0);
        run_tile(0);
        run_tile(1);
        run_tile(2);
        run_tile(3);
        run_tile(4);
        run_tile(0);
        repeat (3) run_tile(1);
        sq = 0; sk = 0; sv = 0; sd = 0;
        s_start = 1;
        sync();
        s_start = 0;
        chk("small_busy", 32'(s_busy), 1);
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (s_q_rd_en || s_k_rd_en || s_v_rd_en) chk("small_addr", 32'({s_q_rd_addr, s_k_rd_addr, s_v_rd_addr}), 0);
            if (s_q_vld) begin sq++; chk("small_q", 32'(s_q_out), 32'h11); end
            if (s_k_vld) begin sk++; chk("small_k", 32'(s_k_out), 32'h22); end
            if (s_v_vld) begin sv++; chk("small_v", 32'(s_v_out), 32'h33); end
            if (s_done) sd++;
        end
        chk("small_counts", 32'({8'(sq), 8'(sk), 8'(sv), 8'(sd)}), 32'h01010101);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
